synth_banked_dual_port_memory: RTL
==================================

// Module: synth_banked_dual_port_memory
// PURPOSE
//  Parametrised successor to the split I/D dual-port memory: two independent request ports onto an
//  instruction bank (region I_BASE) and a data bank (region D_BASE), with byte enables, valid/ready
//  handshakes, same-word conflict arbitration and sticky error capture. Sits between pipeline fetch/
//  mem stages (or debug/IO master) and on-chip RAM; synthesizes to two true-dual-port BRAMs.
// PARAMETERS
//  N         32      data/address width; multiple of 8
//  I_WIDTH   9       I-bank index bits; I_LENGTH = 2**I_WIDTH words
//  D_WIDTH   10      D-bank index bits; D_LENGTH = 2**D_WIDTH words
//  I_BASE    12'h400 addr[31:20] selecting I-bank
//  D_BASE    12'h000 addr[31:20] selecting D-bank
//  RD_ERR    32'hDEAD_BEEF  dout value returned for an errored read
// PORTS
//  clk        in   1     clock; all state on rising edge
//  rstb       in   1     synchronous, active-low reset
//  error      out  1     sticky: any port issued an illegal access since reset
//  err_addr   out  N     address of first illegal access (0 until then)
//  req{p}     in   1     port p (p=0,1) request valid
//  wr_ena{p}  in   1     1 = write, 0 = read; qualified by req{p}
//  be{p}      in   N/8   byte enables for writes; be[k] -> din[8k+7:8k]
//  addr{p}    in   N     byte address, word aligned
//  din{p}     in   N     write data
//  ready{p}   out  1     request accepted this cycle when req{p}&ready{p}
//  rvalid{p}  out  1     read data valid (one cycle pulse)
//  dout{p}    out  N     read data; holds last value between rvalid pulses
// BEHAVIOUR
//  Reset (rstb=0 at edge): error=0, err_addr=0, rvalid0/1=0, dout0/1=0, prio=0; RAM contents kept.
//   In-flight reads are dropped (no rvalid after reset). ready{p} is 0 while rstb=0.
//  Decode: bank = I if addr[31:20]==I_BASE, D if ==D_BASE, else unmapped. Index = addr[W+1:2].
//   Illegal = unmapped, or addr[1:0]!=0, or addr[19:W+2]!=0 (beyond bank length).
//  Accepted write: bytes with be=1 updated at the edge; be=0 bytes untouched; be=0 entirely = no-op.
//  Accepted read: latency 1 -> rvalid{p}=1 next cycle with dout{p}=RAM word (pre-write value if
//   the other port writes the same word in the same cycle is impossible; see conflicts).
//  Illegal access: accepted (ready=1), no RAM write; read returns RD_ERR with rvalid after 1 cycle;
//   error set; err_addr loaded only if error was 0 (first wins; port 0 wins if both same cycle).
//  Conflict: both req, same bank, same index, at least one write. Winner = port prio; loser ready=0.
//   prio toggles to loser after each conflict (round-robin, no starvation). Read/read same word:
//   no conflict, both accepted. Different words or banks: both accepted every cycle.
//  ready{p}=1 whenever rstb=1 and port p does not lose a conflict; masters hold req/addr/din until ready.
//  Back-to-back: one accepted request per port per cycle; rvalid may be high on consecutive cycles.
//  Sim init: $readmemh of INIT_INST/INIT_DATA plusargs (as existing memory); synth: fixed .memh files.
// STRUCTURE
//  Package mips_mem_pkg: region base constants (I_BASE/D_BASE defaults from I_START_ADDRESS),
//   RD_ERR default, decode function (bank, index, illegal).
//  Sub-module be_tdp_ram(WIDTH, DEPTH_BITS): one true-dual-port byte-enable RAM, registered read;
//   instantiated for I-bank and D-bank. Top holds decode, arbiter (prio flop), rvalid/dout regs,
//   last-bank select flops, error/err_addr.
// TESTING
//  1 Write port0 addr 0x0000_0010 din 0x1122_3344 be 4'b1111; read port1 same addr next cycle
//    -> rvalid1 one cycle later, dout1=0x1122_3344.
//  2 Byte enables: word =0x1122_3344, write din 0xAABB_CCDD be 4'b0101 -> readback 0x11BB_33DD.
//  3 Conflict: both write 0x0000_0020 same cycle (0x1,0x2), prio=0 -> ready0=1, ready1=0; next cycle
//    port1 accepted; final read =0x2; repeat conflict -> port1 now wins first.
//  4 Read/read same word 0x4000_0004 both ports -> both ready, both rvalid, equal dout = I-bank word1.
//  5 Illegal: read 0x8000_0000 then write 0x0000_0002 -> rvalid, dout=0xDEAD_BEEF, error=1,
//    err_addr=0x8000_0000 (not overwritten), RAM unchanged.
//  6 Reset mid-op: read issued, rstb=0 next edge -> no rvalid, error=0, RAM data preserved.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: region constants, bank/select encodings and the address decoder
package mips_mem_pkg;
  localparam logic [11:0] I_START_ADDRESS = 12'h400;
  localparam logic [11:0] DEF_I_BASE      = I_START_ADDRESS;
  localparam logic [11:0] DEF_D_BASE      = 12'h000;
  localparam logic [31:0] DEF_RD_ERR      = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {BANK_NONE, BANK_I, BANK_D} bank_e;
  typedef enum logic [1:0] {SEL_ZERO, SEL_I, SEL_D, SEL_ERR} sel_e;
  typedef struct packed {
    bank_e bank;
    logic  illegal;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] a, input logic [11:0] i_base, input logic [11:0] d_base,
                                  input int i_width, input int d_width);
    dec_t r;
    logic [17:0] word;
    word = a[19:2];
    r.bank = a[31:20] == i_base ? BANK_I : a[31:20] == d_base ? BANK_D : BANK_NONE;
    r.illegal = r.bank == BANK_NONE || |a[1:0] || |(word >> (r.bank == BANK_I ? i_width : d_width));
    return r;
  endfunction
endpackage

// File: rtl/be_tdp_ram.sv
// be_tdp_ram: true-dual-port RAM with per-byte write enables and registered, read-enabled outputs
module be_tdp_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 9
) (
  input  logic                  clk,
  input  logic                  re_a,
  input  logic [WIDTH/8-1:0]    we_a,
  input  logic [DEPTH_BITS-1:0] addr_a,
  input  logic [WIDTH-1:0]      din_a,
  output logic [WIDTH-1:0]      q_a,
  input  logic                  re_b,
  input  logic [WIDTH/8-1:0]    we_b,
  input  logic [DEPTH_BITS-1:0] addr_b,
  input  logic [WIDTH-1:0]      din_b,
  output logic [WIDTH-1:0]      q_b
);
  logic [WIDTH-1:0] mem [2**DEPTH_BITS];
  // outputs only move on a read, so they hold the last word read by that port
  always_ff @(posedge clk) begin
    if (re_a) q_a <= mem[addr_a];
    if (re_b) q_b <= mem[addr_b];
    for (int k = 0; k < WIDTH/8; k++) begin
      if (we_a[k]) mem[addr_a][8*k +: 8] <= din_a[8*k +: 8];
      if (we_b[k]) mem[addr_b][8*k +: 8] <= din_b[8*k +: 8];
    end
  end
endmodule

// File: rtl/synth_banked_dual_port_memory.sv
// synth_banked_dual_port_memory: two request ports onto I/D banks with byte enables,
// same-word round-robin arbitration and sticky first-error capture
module synth_banked_dual_port_memory import mips_mem_pkg::*; #(
  parameter int          N       = 32,
  parameter int          I_WIDTH = 9,
  parameter int          D_WIDTH = 10,
  parameter logic [11:0] I_BASE  = DEF_I_BASE,
  parameter logic [11:0] D_BASE  = DEF_D_BASE,
  parameter logic [N-1:0] RD_ERR = N'(DEF_RD_ERR)
) (
  input  logic           clk,
  input  logic           rstb,
  output logic           error,
  output logic [N-1:0]   err_addr,
  input  logic           req0,
  input  logic           wr_ena0,
  input  logic [N/8-1:0] be0,
  input  logic [N-1:0]   addr0,
  input  logic [N-1:0]   din0,
  output logic           ready0,
  output logic           rvalid0,
  output logic [N-1:0]   dout0,
  input  logic           req1,
  input  logic           wr_ena1,
  input  logic [N/8-1:0] be1,
  input  logic [N-1:0]   addr1,
  input  logic [N-1:0]   din1,
  output logic           ready1,
  output logic           rvalid1,
  output logic [N-1:0]   dout1
);
  dec_t               dec      [2];
  logic [N-1:0]       addr_v   [2];
  logic [N/8-1:0]     be_v     [2];
  logic [N/8-1:0]     i_we     [2];
  logic [N/8-1:0]     d_we     [2];
  logic [I_WIDTH-1:0] i_idx    [2];
  logic [D_WIDTH-1:0] d_idx    [2];
  logic [N-1:0]       i_rd     [2];
  logic [N-1:0]       d_rd     [2];
  logic [N-1:0]       dout_v   [2];
  sel_e               sel_q    [2];
  sel_e               sel_d    [2];
  logic [1:0]         req, wr, ready, acc, ill, i_re, d_re, rvalid_q, rvalid_d;
  logic               conflict, prio_q, prio_d, error_q, error_d;
  logic [N-1:0]       err_addr_q, err_addr_d;
  always_comb begin
    req       = {req1, req0};
    wr        = {wr_ena1, wr_ena0};
    addr_v[0] = addr0;
    addr_v[1] = addr1;
    be_v[0]   = be0;
    be_v[1]   = be1;
    for (int p = 0; p < 2; p++) dec[p] = decode(addr_v[p][31:0], I_BASE, D_BASE, I_WIDTH, D_WIDTH);
    // legal addresses in one bank share a word exactly when their word offsets match
    conflict = &req && !dec[0].illegal && !dec[1].illegal && dec[0].bank == dec[1].bank &&
               addr0[19:2] == addr1[19:2] && |wr;
    ready    = {rstb && !(conflict && !prio_q), rstb && !(conflict && prio_q)};
    acc      = req & ready;
    prio_d   = conflict ? !prio_q : prio_q;
    rvalid_d = acc & ~wr;
    for (int p = 0; p < 2; p++) begin
      ill[p]   = dec[p].illegal;
      i_idx[p] = addr_v[p][I_WIDTH+1:2];
      d_idx[p] = addr_v[p][D_WIDTH+1:2];
      i_re[p]  = acc[p] && !ill[p] && !wr[p] && dec[p].bank == BANK_I;
      d_re[p]  = acc[p] && !ill[p] && !wr[p] && dec[p].bank == BANK_D;
      i_we[p]  = acc[p] && !ill[p] && wr[p] && dec[p].bank == BANK_I ? be_v[p] : '0;
      d_we[p]  = acc[p] && !ill[p] && wr[p] && dec[p].bank == BANK_D ? be_v[p] : '0;
      sel_d[p] = !rvalid_d[p] ? sel_q[p] : ill[p] ? SEL_ERR : dec[p].bank == BANK_I ? SEL_I : SEL_D;
      dout_v[p] = sel_q[p] == SEL_ERR ? RD_ERR : sel_q[p] == SEL_I ? i_rd[p] :
                  sel_q[p] == SEL_D ? d_rd[p] : '0;
    end
    error_d    = error_q || |(acc & ill);
    err_addr_d = error_q ? err_addr_q : acc[0] && ill[0] ? addr0 : acc[1] && ill[1] ? addr1 : err_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      prio_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      rvalid_q   <= '0;
      sel_q[0]   <= SEL_ZERO;
      sel_q[1]   <= SEL_ZERO;
    end else begin
      prio_q     <= prio_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      rvalid_q   <= rvalid_d;
      sel_q[0]   <= sel_d[0];
      sel_q[1]   <= sel_d[1];
    end
  end
  be_tdp_ram #(.WIDTH(N), .DEPTH_BITS(I_WIDTH)) u_i_bank (
    .clk(clk),
    .re_a(i_re[0]), .we_a(i_we[0]), .addr_a(i_idx[0]), .din_a(din0), .q_a(i_rd[0]),
    .re_b(i_re[1]), .we_b(i_we[1]), .addr_b(i_idx[1]), .din_b(din1), .q_b(i_rd[1])
  );
  be_tdp_ram #(.WIDTH(N), .DEPTH_BITS(D_WIDTH)) u_d_bank (
    .clk(clk),
    .re_a(d_re[0]), .we_a(d_we[0]), .addr_a(d_idx[0]), .din_a(din0), .q_a(d_rd[0]),
    .re_b(d_re[1]), .we_b(d_we[1]), .addr_b(d_idx[1]), .din_b(din1), .q_b(d_rd[1])
  );
  assign ready0   = ready[0];
  assign ready1   = ready[1];
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign dout0    = dout_v[0];
  assign dout1    = dout_v[1];
  assign error    = error_q;
  assign err_addr = err_addr_q;
endmodule
